// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: two-master round-robin bus arbiter with an integrated
// master-to-slave multiplexer. Grants are taken straight from the state
// register, so they are registered. The slave-side mux is combinational
// from that state.
//
// Optional feature: define BUS_TIMEOUT_EN to enable a hold counter. When it
// is enabled, an owner that has held the bus for MAX_HOLD cycles while the
// other master waits is forced to hand over the bus.
module bus_rr_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_wr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_wr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              bus_busy,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_din
);

  // MAX_HOLD must fit the 8-bit hold counter and leave room for at least one
  // cycle of ownership before a forced handover.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    M0   = 2'b01,
    M1   = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  // Index of the master most recently granted. Reset to 1 so that master 0
  // wins the first contention.
  logic   last;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       hold_expired;
  logic       owner_entry;

  assign hold_expired = (hold_cnt == HOLD_LIMIT);
  assign owner_entry  = (state_nxt != state) && (state_nxt != IDLE);

  // Hold counter: cleared on each new ownership and while idle. It counts
  // cycles of continued ownership and saturates at MAX_HOLD-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (owner_entry || (state_nxt == IDLE)) begin
      hold_cnt <= '0;
    end else if (!hold_expired) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`endif

  // State register plus round-robin history. last follows every entry into
  // M0 or M1. Re-loading the same value while staying in a state is harmless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == M0) begin
        last <= 1'b0;
      end else if (state_nxt == M1) begin
        last <= 1'b1;
      end
    end
  end

  // Next-state selection: round-robin on contention from IDLE, direct
  // handover when the owner releases, and no preemption unless the hold
  // limit is enabled and has been reached.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = last ? M0 : M1;
        end else if (m0_req) begin
          state_nxt = M0;
        end else if (m1_req) begin
          state_nxt = M1;
        end else begin
          state_nxt = IDLE;
        end
      end
      M0: begin
        if (!m0_req) begin
          state_nxt = m1_req ? M1 : IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (hold_expired && m1_req) begin
          state_nxt = M1;
        end
`endif
      end
      M1: begin
        if (!m1_req) begin
          state_nxt = m0_req ? M0 : IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (hold_expired && m0_req) begin
          state_nxt = M0;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_grant = (state == M0);
  assign m1_grant = (state == M1);
  assign bus_busy = m0_grant | m1_grant;

  // Slave-side mux. It drives zeros while idle, so s_wr is never asserted
  // without a grant.
  always_comb begin
    s_address = '0;
    s_wr      = 1'b0;
    s_din     = '0;
    unique case (state)
      M0: begin
        s_address = m0_address;
        s_wr      = m0_wr;
        s_din     = m0_dout;
      end
      M1: begin
        s_address = m1_address;
        s_wr      = m1_wr;
        s_din     = m1_dout;
      end
      default: begin
        s_address = '0;
        s_wr      = 1'b0;
        s_din     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter. Each clock step runs a reference
// model on the driven requests and queues the expected owner. After the
// clock edge, the expected owner is popped and compared with the grants and
// the mux outputs.
module tb_bus_rr_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              m0_req, m1_req;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic              m0_wr, m1_wr;
  logic [DATA_W-1:0] m0_dout, m1_dout;
  logic              m0_grant, m1_grant, bus_busy;
  logic [ADDR_W-1:0] s_address;
  logic              s_wr;
  logic [DATA_W-1:0] s_din;

  int checks = 0;
  int errors = 0;

  // Expected owner after each edge: -1 idle, 0 or 1 for the granted master.
  int exp_q[$];

  int mdl_owner;
  bit mdl_last;
  int mdl_held;

  bus_rr_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_address(m0_address),
    .m0_wr     (m0_wr),
    .m0_dout   (m0_dout),
    .m1_address(m1_address),
    .m1_wr     (m1_wr),
    .m1_dout   (m1_dout),
    .m0_grant  (m0_grant),
    .m1_grant  (m1_grant),
    .bus_busy  (bus_busy),
    .s_address (s_address),
    .s_wr      (s_wr),
    .s_din     (s_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = 1'b1;
    mdl_held  = 0;
  endtask

  // Reference model. mdl_held counts the cycles the current owner has held
  // the bus, including the cycle in progress.
  function automatic int model_next(logic r0, logic r1);
    logic [1:0] rq;
    int nxt;
    rq = {r1, r0};
    if (mdl_owner < 0) begin
      if (r0 && r1)  nxt = mdl_last ? 0 : 1;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else if (!rq[mdl_owner]) begin
      nxt = rq[1-mdl_owner] ? 1 - mdl_owner : -1;
    end else if (TO_EN && mdl_held >= MAX_HOLD && rq[1-mdl_owner]) begin
      nxt = 1 - mdl_owner;
    end else begin
      nxt = mdl_owner;
    end
    if (nxt < 0) begin
      mdl_held = 0;
    end else if (nxt == mdl_owner) begin
      mdl_held++;
    end else begin
      mdl_held = 1;
      mdl_last = (nxt == 1);
    end
    mdl_owner = nxt;
    return nxt;
  endfunction

  task automatic check_out(input string tag);
    int own;
    logic [ADDR_W-1:0] ea;
    logic              ew;
    logic [DATA_W-1:0] ed;
    chk({tag, "_qdepth"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    own = exp_q.pop_front();
    ea = '0; ew = 1'b0; ed = '0;
    if (own == 0) begin ea = m0_address; ew = m0_wr; ed = m0_dout; end
    if (own == 1) begin ea = m1_address; ew = m1_wr; ed = m1_dout; end
    chk({tag, "_g0"},   m0_grant, own == 0);
    chk({tag, "_g1"},   m1_grant, own == 1);
    chk({tag, "_busy"}, bus_busy, own != -1);
    chk({tag, "_addr"}, s_address, ea);
    chk({tag, "_wr"},   s_wr, ew);
    chk({tag, "_din"},  s_din, ed);
  endtask

  task automatic step(input string tag);
    exp_q.push_back(model_next(m0_req, m1_req));
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    #2;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int first_idx;
    reset_n    = 1'b0;
    m0_req     = 1'b0;
    m1_req     = 1'b0;
    m0_address = 8'hA5;
    m1_address = 8'h3C;
    m0_wr      = 1'b1;
    m1_wr      = 1'b1;
    m0_dout    = 32'h0000_1111;
    m1_dout    = 32'h2222_0000;
    model_reset();

    // Reset state: idle outputs are zero even though the masters drive nonzero values.
    #12;
    chk("rst_g0",   m0_grant, 1'b0);
    chk("rst_g1",   m1_grant, 1'b0);
    chk("rst_busy", bus_busy, 1'b0);
    chk("rst_wr",   s_wr, 1'b0);
    chk("rst_addr", s_address, '0);
    chk("rst_din",  s_din, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester.
    step("idle");
    m1_req = 1'b1;
    step("m1_only");
    chk("m1_only_addr_const", s_address, 8'h3C);
    m1_req = 1'b0;
    step("m1_release");

    // Simultaneous requests after reset: master 0 first, then a direct handover.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    step("both_first");
    m0_req = 1'b0;
    step("handover");
    m1_req = 1'b0;
    step("handover_idle");

    // Alternation: each owner drops its request for one cycle after 3 granted cycles.
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("alt");
      chk("alt_onehot", m0_grant & m1_grant, 1'b0);
      m0_req = !(mdl_owner == 0 && mdl_held == 3);
      m1_req = !(mdl_owner == 1 && mdl_held == 3);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step("alt_end");

    // Mux: master 0 writes, and the master 1 inputs must not leak to the slave side.
    m0_req = 1'b1; m0_wr = 1'b1; m0_dout = 32'hDEADBEEF;
    step("mux_m0");
    chk("mux_din_const", s_din, 32'hDEADBEEF);
    m1_address = 8'hF0; m1_wr = 1'b0; m1_dout = 32'h1234_5678;
    #1;
    chk("mux_iso_din",  s_din, 32'hDEADBEEF);
    chk("mux_iso_wr",   s_wr, 1'b1);
    chk("mux_iso_addr", s_address, 8'hA5);
    m0_req = 1'b0;
    step("mux_release");

    // Asynchronous reset while master 1 holds the bus.
    m1_req = 1'b1;
    step("pre_async");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_g1",   m1_grant, 1'b0);
    chk("async_g0",   m0_grant, 1'b0);
    chk("async_wr",   s_wr, 1'b0);
    chk("async_addr", s_address, '0);
    model_reset();
    exp_q.delete();
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step("post_async");
    chk("post_async_m0first", m0_grant, 1'b1);

    // Hold limit: m0 holds the bus continuously and m1 starts requesting in m0's first cycle.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b0;
    step("to_enter");
    m1_req = 1'b1;
    first_idx = 99;
    for (int i = 1; i <= 6; i++) begin
      step("to_hold");
      if (m1_grant && first_idx == 99) first_idx = i;
    end
    chk("to_handover_step", first_idx, TO_EN ? 4 : 99);
    m0_req = 1'b0;
    step("to_release");
    m1_req = 1'b0;
    step("to_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time, so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Two-master round-robin bus arbiter with an integrated master-to-slave bus multiplexer. It sits between two bus masters (e.g. CPU and DMA) and the shared slave bus. It grants exactly one master at a time and forwards the granted master's address, write strobe and write data to the slaves. It extends single-master request/grant sequencing to fair sharing between contending requesters.

Parameters:
ADDR_W, 8, width of master and slave address buses
DATA_W, 32, width of write data buses
MAX_HOLD, 16, maximum consecutive grant cycles while the other master waits (used only with BUS_TIMEOUT_EN); legal range 2..255

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
m0_req  input  1  master 0 bus request, level, held for the whole transfer
m1_req  input  1  master 1 bus request, level
m0_address  input  ADDR_W  master 0 address
m0_wr  input  1  master 0 write strobe
m0_dout  input  DATA_W  master 0 write data
m1_address  input  ADDR_W  master 1 address
m1_wr  input  1  master 1 write strobe
m1_dout  input  DATA_W  master 1 write data
m0_grant  output  1  master 0 owns bus (registered)
m1_grant  output  1  master 1 owns bus (registered)
bus_busy  output  1  m0_grant | m1_grant
s_address  output  ADDR_W  muxed address to slaves
s_wr  output  1  muxed write strobe to slaves
s_din  output  DATA_W  muxed write data to slaves

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, m0_grant=0, m1_grant=0, last=1 (master 0 wins the first contention), hold counter=0. All outputs are 0.
- States: IDLE, M0, M1. Grants are registered, so a grant rises one cycle after the request is sampled and falls one cycle after the request drops. m0_grant=(state==M0) and m1_grant=(state==M1); the grants are one-hot or zero.
- IDLE transitions:
  - only m0_req -> M0.
  - only m1_req -> M1.
  - both requesting -> the master not named by `last` (round-robin).
  - neither -> stay IDLE.
- M0 transitions:
  - m0_req=1 -> stay in M0 (no preemption without the optional feature).
  - m0_req=0 and m1_req=1 -> M1 directly, with no IDLE bubble.
  - m0_req=0 and m1_req=0 -> IDLE.
- M1 transitions: symmetric to M0.
- `last` update: set to the index of the master on every entry into M0 or M1.
- Mux: purely combinational from the state register.
  - M0 -> s_* = m0_*.
  - M1 -> s_* = m1_*.
  - IDLE -> s_address=0, s_wr=0, s_din=0. s_wr is never asserted without a grant.
- Request dropped and re-raised in the same cycle as a handover: the request is evaluated on the sampled level only; no glitch filtering.
- Reset mid-transfer: both grants drop asynchronously, mux outputs go to 0, and `last` returns to 1.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - An 8-bit hold counter clears on every entry into M0 or M1 and increments each cycle the state stays in M0 or M1. It saturates at MAX_HOLD-1.
  - If the count equals MAX_HOLD-1 and the other master is requesting, the next state is the other master's state even if the current request is still high (forced handover). `last` updates as normal.
  - If the other master is not requesting, the current owner keeps the bus and the counter stays saturated.
  - Effect: a waiting master is granted no later than MAX_HOLD+1 cycles after its request.
- Undefined: no counter exists and the owner holds the bus for as long as its request stays high.

Test Plan:
- Reset with all requests low -> grants 0, s_wr=0, s_address=0. Assert m1_req only -> m1_grant=1 on the next edge; s_address=m1_address.
- m0_req and m1_req rise in the same cycle after reset -> m0_grant first. Drop m0_req -> m1_grant=1 on the next edge with no idle cycle and m0_grant=0.
- Both masters request continuously and each drops its request for 1 cycle after 3 granted cycles -> grants alternate M0, M1, M0, M1; never both high.
- In M0 with m0_wr=1 and m0_dout=0xDEADBEEF -> s_wr=1 and s_din=0xDEADBEEF combinationally. Change m1 inputs -> s_* unchanged.
- Assert reset_n=0 mid-grant while m1_grant=1 -> grants drop immediately without a clock edge. Release reset with both requesting -> m0_grant first.
- With BUS_TIMEOUT_EN and MAX_HOLD=4: m0_req held high, m1_req raised in M0 cycle 1 -> m1_grant=1 after m0 has held the bus for 4 cycles. Without the macro -> m1_grant stays 0 until m0_req drops.
